// File: rtl/emperor_axi_pkg.sv
// Shared AXI definitions: master FSM state encoding and AXI response codes.
package emperor_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } axi_mst_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A channel that never completes is reported with the DECERR encoding.
    localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

endpackage

// File: rtl/axi_lite_mmio_master.sv
// Single-outstanding AXI4-Lite MMIO master: a command/response front end driving the
// master side of emperor_axi_lite_if, with a per-state watchdog that forces a DECERR response.
module axi_lite_mmio_master
    import emperor_axi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        aclk,
    input  logic        arst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,

    output logic [31:0] M_AXI_awaddr,
    output logic [2:0]  M_AXI_awprot,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,
    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,
    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready,
    output logic [31:0] M_AXI_araddr,
    output logic [2:0]  M_AXI_arprot,
    output logic        M_AXI_arvalid,
    input  logic        M_AXI_arready,
    input  logic [31:0] M_AXI_rdata,
    input  logic [1:0]  M_AXI_rresp,
    input  logic        M_AXI_rvalid,
    output logic        M_AXI_rready
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    axi_mst_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic [1:0]       rsp_resp_q;

    logic [31:0]      awaddr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      araddr_q;
    logic             awvalid_q;
    logic             wvalid_q;
    logic             bready_q;
    logic             arvalid_q;
    logic             rready_q;

    logic             aw_done_s;
    logic             w_done_s;
    logic             timeout_s;

    // A write channel counts as done once its valid has dropped or handshakes this cycle.
    always_comb begin
        aw_done_s = !awvalid_q || M_AXI_awready;
        w_done_s  = !wvalid_q  || M_AXI_wready;
        timeout_s = (cnt_q == CNT_LAST);
    end

    // Transaction FSM; every interface output is a register updated here.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_resp_q  <= RESP_OKAY;
            awaddr_q    <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'h0;
            araddr_q    <= 32'h0000_0000;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_write) begin
                            state_q   <= WR_REQ;
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_REQ;
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                WR_REQ: begin
                    if (aw_done_s && w_done_s) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WR_RESP;
                    end else if (timeout_s) begin
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= RESP_TIMEOUT;
                        rsp_rdata_q <= 32'h0000_0000;
                        state_q     <= RSP;
                    end else begin
                        if (awvalid_q && M_AXI_awready) begin
                            awvalid_q <= 1'b0;
                        end
                        if (wvalid_q && M_AXI_wready) begin
                            wvalid_q <= 1'b0;
                        end
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        bready_q    <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= M_AXI_bresp;
                        rsp_rdata_q <= 32'h0000_0000;
                        state_q     <= RSP;
                    end else if (timeout_s) begin
                        bready_q    <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= RESP_TIMEOUT;
                        rsp_rdata_q <= 32'h0000_0000;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                RD_REQ: begin
                    if (M_AXI_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RD_RESP;
                    end else if (timeout_s) begin
                        arvalid_q   <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= RESP_TIMEOUT;
                        rsp_rdata_q <= 32'h0000_0000;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                RD_RESP: begin
                    if (M_AXI_rvalid) begin
                        rready_q    <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= M_AXI_rresp;
                        rsp_rdata_q <= M_AXI_rdata;
                        state_q     <= RSP;
                    end else if (timeout_s) begin
                        rready_q    <= 1'b0;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= RESP_TIMEOUT;
                        rsp_rdata_q <= 32'h0000_0000;
                        state_q     <= RSP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                RSP: begin
                    cnt_q <= '0;
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign M_AXI_awaddr  = awaddr_q;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awvalid = awvalid_q;
    assign M_AXI_wdata   = wdata_q;
    assign M_AXI_wstrb   = wstrb_q;
    assign M_AXI_wvalid  = wvalid_q;
    assign M_AXI_bready  = bready_q;
    assign M_AXI_araddr  = araddr_q;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arvalid = arvalid_q;
    assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_mmio_master.sv
// Directed bench for axi_lite_mmio_master: a latency-programmable AXI-Lite slave plus
// hand-computed expectations for latency, handshake counts, responses and reset behaviour.
module tb_axi_lite_mmio_master;

    localparam int unsigned TO = 16;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_awaddr;
    logic [2:0]  M_AXI_awprot;
    logic        M_AXI_awvalid;
    logic        M_AXI_awready = 1'b0;
    logic [31:0] M_AXI_wdata;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_wvalid;
    logic        M_AXI_wready = 1'b0;
    logic [1:0]  M_AXI_bresp = 2'b00;
    logic        M_AXI_bvalid = 1'b0;
    logic        M_AXI_bready;
    logic [31:0] M_AXI_araddr;
    logic [2:0]  M_AXI_arprot;
    logic        M_AXI_arvalid;
    logic        M_AXI_arready = 1'b0;
    logic [31:0] M_AXI_rdata = 32'h0;
    logic [1:0]  M_AXI_rresp = 2'b00;
    logic        M_AXI_rvalid = 1'b0;
    logic        M_AXI_rready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Slave knobs: cycles a valid/pending item waits before the slave answers.
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    bit          b_never = 1'b0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = 32'h0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;

    int          awv_cyc, wv_cyc, arv_cyc, brdy_cyc, brdy_ph, rrdy_cyc;
    logic        brdy_prev = 1'b0;

    axi_lite_mmio_master #(.TIMEOUT_CYC(TO)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awvalid(M_AXI_awvalid),
        .M_AXI_awready(M_AXI_awready), .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
        .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp),
        .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready), .M_AXI_araddr(M_AXI_araddr),
        .M_AXI_arprot(M_AXI_arprot), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
        .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rvalid(M_AXI_rvalid),
        .M_AXI_rready(M_AXI_rready)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] out_vec();
        return 256'({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, M_AXI_awaddr, M_AXI_awprot,
                     M_AXI_awvalid, M_AXI_wdata, M_AXI_wstrb, M_AXI_wvalid, M_AXI_bready,
                     M_AXI_araddr, M_AXI_arprot, M_AXI_arvalid, M_AXI_rready});
    endfunction

    // Slave model and channel monitor, evaluated on the falling edge.
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c;
        bit aw_got, w_got, wr_pend, rd_pend;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        aw_got = 1'b0; w_got = 1'b0; wr_pend = 1'b0; rd_pend = 1'b0;
        forever begin
            @(negedge aclk);
            if (!arst_n) begin
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                aw_got = 1'b0; w_got = 1'b0; wr_pend = 1'b0; rd_pend = 1'b0;
                M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_arready = 1'b0;
                M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b00;
                M_AXI_rvalid = 1'b0; M_AXI_rresp = 2'b00; M_AXI_rdata = 32'h0;
                brdy_prev = 1'b0;
            end else begin
                M_AXI_bvalid = wr_pend && !b_never && (b_c >= b_lat);
                M_AXI_bresp  = M_AXI_bvalid ? bresp_v : 2'b00;
                if (wr_pend) begin
                    if (M_AXI_bvalid && M_AXI_bready) wr_pend = 1'b0;
                    else b_c++;
                end
                M_AXI_rvalid = rd_pend && (r_c >= r_lat);
                M_AXI_rdata  = M_AXI_rvalid ? rdata_v : 32'h0;
                M_AXI_rresp  = M_AXI_rvalid ? rresp_v : 2'b00;
                if (rd_pend) begin
                    if (M_AXI_rvalid && M_AXI_rready) rd_pend = 1'b0;
                    else r_c++;
                end
                M_AXI_awready = M_AXI_awvalid && (aw_c >= aw_lat);
                aw_c = M_AXI_awvalid ? aw_c + 1 : 0;
                M_AXI_wready = M_AXI_wvalid && (w_c >= w_lat);
                w_c = M_AXI_wvalid ? w_c + 1 : 0;
                M_AXI_arready = M_AXI_arvalid && (ar_c >= ar_lat);
                ar_c = M_AXI_arvalid ? ar_c + 1 : 0;
                if (M_AXI_awvalid && M_AXI_awready) aw_got = 1'b1;
                if (M_AXI_wvalid && M_AXI_wready) w_got = 1'b1;
                if (aw_got && w_got) begin
                    wr_pend = 1'b1; b_c = 0; aw_got = 1'b0; w_got = 1'b0;
                end
                if (M_AXI_arvalid && M_AXI_arready) begin
                    rd_pend = 1'b1; r_c = 0;
                end
                if (M_AXI_awvalid) begin
                    awv_cyc++;
                    check_eq("awaddr_stable", 256'(M_AXI_awaddr), 256'(exp_addr));
                end
                if (M_AXI_wvalid) begin
                    wv_cyc++;
                    check_eq("wdata_stable", 256'({M_AXI_wstrb, M_AXI_wdata}), 256'({exp_wstrb, exp_wdata}));
                end
                if (M_AXI_arvalid) begin
                    arv_cyc++;
                    check_eq("araddr_stable", 256'(M_AXI_araddr), 256'(exp_addr));
                end
                if (M_AXI_bready) brdy_cyc++;
                if (M_AXI_bready && !brdy_prev) brdy_ph++;
                brdy_prev = M_AXI_bready;
                if (M_AXI_rready) rrdy_cyc++;
            end
        end
    end

    task automatic run_cmd(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int hold,
                           output int lat, output logic [31:0] rdata, output logic [1:0] resp);
        int n;
        bit got;
        exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
        @(negedge aclk);
        awv_cyc = 0; wv_cyc = 0; arv_cyc = 0; brdy_cyc = 0; brdy_ph = 0; rrdy_cyc = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check_eq({tag, "_accept"}, 256'(cmd_ready), 256'(1));
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        got = 1'b0; lat = 0; rdata = 32'h0; resp = 2'b00;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge aclk);
            if (rsp_valid) begin
                got = 1'b1; lat = i; rdata = rsp_rdata; resp = rsp_resp;
            end
        end
        check_eq({tag, "_rsp_seen"}, 256'(got), 256'(1));
        if (got) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge aclk);
                check_eq({tag, "_rsp_hold"}, 256'({rsp_valid, rsp_resp, rsp_rdata}), 256'({1'b1, resp, rdata}));
            end
            rsp_ready = 1'b1;
            @(posedge aclk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic [1:0] rs;
        bit seen;

        #12;
        check_eq("reset_outputs", out_vec(), 256'(0));
        @(negedge aclk);
        @(negedge aclk);
        arst_n = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check_eq("idle_ready", 256'({cmd_ready, rsp_valid}), 256'(2'b10));

        // Zero-wait write
        run_cmd("wr0", 1'b1, 32'h4600_0104, 32'hA5A5_A5A5, 4'hF, 2, lat, rd, rs);
        check_eq("wr0_latency", 256'(lat), 256'(3));
        check_eq("wr0_resp", 256'({rs, rd}), 256'({2'b00, 32'h0}));
        check_eq("wr0_counts", 256'({awv_cyc, wv_cyc, brdy_cyc, brdy_ph}), 256'({32'd1, 32'd1, 32'd1, 32'd1}));
        @(negedge aclk);
        check_eq("wr0_after", 256'({cmd_ready, rsp_valid}), 256'(2'b10));

        // Read with arready delayed 4 cycles
        ar_lat = 4; rdata_v = 32'h0000_01FF; rresp_v = 2'b00;
        run_cmd("rd0", 1'b0, 32'h4600_0100, 32'h0, 4'h0, 0, lat, rd, rs);
        check_eq("rd0_latency", 256'(lat), 256'(7));
        check_eq("rd0_resp", 256'({rs, rd}), 256'({2'b00, 32'h0000_01FF}));
        check_eq("rd0_counts", 256'({arv_cyc, rrdy_cyc}), 256'({32'd5, 32'd1}));

        // W lags AW by 2 cycles, SLVERR
        ar_lat = 0; aw_lat = 0; w_lat = 2; bresp_v = 2'b10;
        run_cmd("wr1", 1'b1, 32'h4600_0008, 32'h1234_5678, 4'b0101, 0, lat, rd, rs);
        check_eq("wr1_latency", 256'(lat), 256'(5));
        check_eq("wr1_resp", 256'({rs, rd}), 256'({2'b10, 32'h0}));
        check_eq("wr1_counts", 256'({awv_cyc, wv_cyc, brdy_cyc, brdy_ph}), 256'({32'd1, 32'd3, 32'd1, 32'd1}));

        // AW lags W by 3 cycles, bvalid 2 cycles late, DECERR from slave
        aw_lat = 3; w_lat = 0; b_lat = 2; bresp_v = 2'b11;
        run_cmd("wr2", 1'b1, 32'h4600_0010, 32'hCAFE_0001, 4'b1000, 1, lat, rd, rs);
        check_eq("wr2_latency", 256'(lat), 256'(8));
        check_eq("wr2_resp", 256'({rs, rd}), 256'({2'b11, 32'h0}));
        check_eq("wr2_counts", 256'({awv_cyc, wv_cyc, brdy_cyc, brdy_ph}), 256'({32'd4, 32'd1, 32'd3, 32'd1}));

        // Two long but individually legal waits: watchdog must restart per state
        aw_lat = 0; b_lat = 0; bresp_v = 2'b00;
        ar_lat = 10; r_lat = 10; rdata_v = 32'hDEAD_BEEF; rresp_v = 2'b10;
        run_cmd("rd1", 1'b0, 32'h4600_0200, 32'h0, 4'h0, 0, lat, rd, rs);
        check_eq("rd1_latency", 256'(lat), 256'(23));
        check_eq("rd1_resp", 256'({rs, rd}), 256'({2'b10, 32'hDEAD_BEEF}));
        check_eq("rd1_counts", 256'({arv_cyc, rrdy_cyc}), 256'({32'd11,32'd11}));

        // Write response never arrives
        ar_lat = 0; r_lat = 0; b_never = 1'b1;
        run_cmd("wr_to", 1'b1, 32'h4600_0300, 32'h5555_AAAA, 4'h3, 0, lat, rd, rs);
        check_eq("wr_to_latency", 256'(lat), 256'(18));
        check_eq("wr_to_resp", 256'({rs, rd}), 256'({2'b11, 32'h0}));
        check_eq("wr_to_bready", 256'({brdy_cyc, brdy_ph}), 256'({32'd16, 32'd1}));
        b_never = 1'b0;

        // arready never arrives; read data must read back as zero
        ar_lat = 1000;
        run_cmd("rd_to", 1'b0, 32'h4600_0400, 32'h0, 4'h0, 0, lat, rd, rs);
        check_eq("rd_to_latency", 256'(lat), 256'(17));
        check_eq("rd_to_resp", 256'({rs, rd}), 256'({2'b11, 32'h0}));
        check_eq("rd_to_arvalid", 256'(arv_cyc), 256'(16));
        ar_lat = 0;

        // Reset pulsed while waiting in the read-response phase
        r_lat = 12; rdata_v = 32'h0BAD_F00D; rresp_v = 2'b00;
        exp_addr = 32'h4600_0500;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4600_0500;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !M_AXI_rready; i++) @(negedge aclk);
        check_eq("rst_reach_rd_resp", 256'(M_AXI_rready), 256'(1));
        #2 arst_n = 1'b0;
        #1;
        check_eq("rst_midflight_outputs", out_vec(), 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            if (rsp_valid) seen = 1'b1;
        end
        arst_n = 1'b1;
        r_lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rst_no_rsp", 256'(seen), 256'(0));
        check_eq("rst_idle_ready", 256'(cmd_ready), 256'(1));
        run_cmd("wr_post", 1'b1, 32'h4600_0104, 32'h0F0F_F0F0, 4'hF, 0, lat, rd, rs);
        check_eq("wr_post_latency", 256'(lat), 256'(3));
        check_eq("wr_post_resp", 256'({rs, rd}), 256'({2'b00, 32'h0}));

        repeat (3) @(negedge aclk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_mmio_master.md
AXI_LITE_MMIO_MASTER -- requirements
Module: axi_lite_mmio_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256; meaning: maximum cycles waited on any AXI channel before forcing an error response.
REQ-002 SHALL have port aclk  input  1  clock; the block uses this one clock only.
REQ-003 SHALL have port arst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  target byte address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port cmd_wstrb  input  4  write byte strobes.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_rdata  output  32  read data; 0 for writes.
REQ-013 SHALL have port rsp_resp  output  2  AXI response code; 2'b11 on timeout.
REQ-014 SHALL have port M_AXI_awaddr  output  32  write address.
REQ-015 SHALL have port M_AXI_awprot  output  3  protection; tied to 3'b000.
REQ-016 SHALL have port M_AXI_awvalid  output  1  write address valid.
REQ-017 SHALL have port M_AXI_awready  input  1  write address ready.
REQ-018 SHALL have port M_AXI_wdata  output  32  write data.
REQ-019 SHALL have port M_AXI_wstrb  output  4  write strobes.
REQ-020 SHALL have port M_AXI_wvalid  output  1  write data valid.
REQ-021 SHALL have port M_AXI_wready  input  1  write data ready.
REQ-022 SHALL have port M_AXI_bresp  input  2  write response.
REQ-023 SHALL have port M_AXI_bvalid  input  1  write response valid.
REQ-024 SHALL have port M_AXI_bready  output  1  write response ready.
REQ-025 SHALL have port M_AXI_araddr  output  32  read address.
REQ-026 SHALL have port M_AXI_arprot  output  3  protection; tied to 3'b000.
REQ-027 SHALL have port M_AXI_arvalid  output  1  read address valid.
REQ-028 SHALL have port M_AXI_arready  input  1  read address ready.
REQ-029 SHALL have port M_AXI_rdata  input  32  read data.
REQ-030 SHALL have port M_AXI_rresp  input  2  read response.
REQ-031 SHALL have port M_AXI_rvalid  input  1  read data valid.
REQ-032 SHALL have port M_AXI_rready  output  1  read data ready.

Function
REQ-033 SHALL implement FSM IDLE -> WR_REQ -> WR_RESP -> RSP for writes, and IDLE -> RD_REQ -> RD_RESP -> RSP for reads; RSP -> IDLE on the rsp_valid&&rsp_ready handshake.
REQ-034 SHALL assert cmd_ready only in IDLE, and register addr/wdata/wstrb/write on the cmd_valid&&cmd_ready handshake; one transaction outstanding at most.
REQ-035 SHALL assert awvalid and wvalid together in the cycle after command accept, and drop each independently on its own handshake; AW and W handshakes in the same or different cycles are both legal; leave WR_REQ when both are complete.
REQ-036 SHALL hold awaddr/wdata/wstrb/araddr stable while the corresponding valid is high, and never reassert any valid before the response handshake (bvalid&&bready or rvalid&&rready).
REQ-037 SHALL assert bready only in WR_RESP and rready only in RD_RESP; capture bresp, or rdata/rresp, on the handshake; next cycle rsp_valid=1 (minimum latency accept -> rsp_valid is 3 cycles with a zero-wait slave).
REQ-038 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-039 SHALL count cycles in WR_REQ/WR_RESP/RD_REQ/RD_RESP; on reaching TIMEOUT_CYC, drop all valids/readies, go to RSP with rsp_resp=2'b11 and rsp_rdata=0; the counter clears on every state change.

Reset
REQ-040 SHALL, while arst_n=0, asynchronously force state IDLE, every valid/ready output to 0, all data/address/resp outputs and the counter to 0, and abandon any in-flight transaction without emitting a response.

Structure
REQ-041 SHALL take the state enum and the response codes (OKAY, SLVERR, DECERR) from the shared package emperor_axi_pkg; no sub-module is required; it SHALL connect to the existing emperor_axi_lite_if as master.

Verification
REQ-042 SHALL cover: write addr 0x4600_0104, data 0xA5A5_A5A5, strb 0xF, zero-wait slave -> aw/w handshake in 1 cycle, bready, rsp_resp=0 on cycle 3.
REQ-043 SHALL cover: read 0x4600_0100, arready delayed 4 cycles, rdata 0x0000_01FF -> araddr stable throughout, rsp_rdata=0x1FF, resp=0.
REQ-044 SHALL cover: wready 2 cycles after awready -> awvalid drops first, wvalid holds, single bready phase.
REQ-045 SHALL cover: slave never asserts bvalid, TIMEOUT_CYC=16 -> rsp_resp=2'b11 after 16 cycles in WR_RESP.
REQ-046 SHALL cover: arst_n pulsed low during RD_RESP -> all outputs 0 immediately, no rsp_valid, next command processed normally.
